pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage RV32 pipeline. It drives the block/clear controls of the PC register and the four inter-stage registers (L1 IF/ID, L2 ID/EX, L3 EX/MEM, L4 MEM/WB). It resolves load-use hazards, taken-branch/jump redirects, multi-cycle mul/div occupancy in EX and data-memory wait states in MEM. A fixed priority order and a small FSM sequence these events.

Parameters:
MEM_TIMEOUT, 255, consecutive MEM wait cycles before mem_err is raised; legal range 1..(2^TO_W − 1).
TO_W, 8, width of the MEM wait counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_rs1  in  5  rs1 index of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2  in  5  rs2 index of instruction in ID
id_rs2_used  in  1  ID instruction reads rs2
ex_rd  in  5  rd index of instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_redirect  in  1  EX branch taken or jump; PC loads target this edge
ex_md_start  in  1  mul/div instruction in EX, first cycle (1-cycle pulse)
md_done  in  1  mul/div unit result valid (1-cycle pulse)
mem_req  in  1  MEM stage is accessing data memory
mem_ready  in  1  data memory completes access this cycle
block_pc  out  1  hold PC
block_l1, block_l2, block_l3, block_l4  out  1 each  hold register
clear_l1, clear_l2, clear_l3, clear_l4  out  1 each  load bubble (nop 0x13, pc 0)
mem_err  out  1  sticky MEM timeout flag
stall_cycles  out  32  perf counter (see Optional Feature)
flush_count  out  32  perf counter (see Optional Feature)

Behaviour:
- All block/clear outputs are combinational from the current state, current inputs and registered flags. No added latency.
- FSM states: RUN, MD_WAIT. Registered flags: md_done_pend, wait_cnt[TO_W-1:0], mem_err.
- Reset (rst=1, any state): state←RUN, md_done_pend←0, wait_cnt←0, mem_err←0, counters←0. While rst=1: clear_l1..l4=1 and all block_*=0. Reset mid-stall abandons the stall.
- Derived conditions:
  - mem_stall = mem_req & ~mem_ready.
  - md_stall = (ex_md_start | state==MD_WAIT) & ~(md_done | md_done_pend).
  - load_use = ex_is_load & ex_rd≠0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Priority, first match wins. All unlisted outputs are 0.
  1. mem_stall: block_pc, block_l1, block_l2, block_l3; clear_l4.
  2. md_stall: block_pc, block_l1, block_l2; clear_l3.
  3. ex_redirect: clear_l1, clear_l2. PC is not blocked.
  4. load_use: block_pc, block_l1; clear_l2. Exactly one bubble per hazard.
  5. none: all 0.
- Redirect during a mem or md stall is deferred. EX is frozen, so ex_redirect stays asserted and is acted on in the first unstalled cycle.
- FSM transitions:
  - RUN→MD_WAIT: ex_md_start & ~md_done.
  - MD_WAIT→RUN: (md_done | md_done_pend) & ~mem_stall.
  - ex_md_start with md_done in the same cycle: stays in RUN, no stall.
- md_done while mem_stall=1: md_done_pend←1. It is cleared when the FSM returns to RUN. A pending done is never lost.
- MEM wait counter:
  - wait_cnt increments (saturating) each mem_stall cycle and clears on any cycle with mem_stall=0.
  - When wait_cnt reaches MEM_TIMEOUT, mem_err←1, held until rst.
  - The stall itself continues regardless of mem_err.
- ex_rd=0 never produces a load-use stall.

Optional Feature:
Macro: HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each cycle with block_pc=1.
  - flush_count increments each cycle the redirect branch (priority 3) is taken.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by rst.
- Undefined: both outputs are constant 0 and no counter flops are synthesized. All other behaviour is identical.

Test Plan:
1. Load-use: EX lw with ex_rd=5; ID with id_rs1=5, id_rs1_used=1 → one cycle of block_pc=block_l1=clear_l2=1. Next cycle (load moved on) all 0. Repeat with ex_rd=0 → no stall.
2. Redirect vs load-use in the same cycle: ex_redirect=1 and load_use=1 → clear_l1=clear_l2=1, block_pc=0. flush_count +1 when HAZ_PERF_CNT_EN is defined.
3. Mul/div: ex_md_start pulse, md_done 4 cycles later:
   - stall (block_pc/l1/l2, clear_l3) for 4 cycles, state MD_WAIT;
   - release on the md_done cycle;
   - stall_cycles +4.
4. Overlap: in MD_WAIT, mem_req=1, mem_ready=0 for 3 cycles with md_done pulsing in the 2nd:
   - mem priority outputs (clear_l4, block_l3) for 3 cycles;
   - md_done_pend=1;
   - RUN after mem_ready, with no further md stall.
5. Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held → mem_err rises on the 4th stall cycle and stays 1 after mem_ready. It clears only after a 1-cycle rst.
6. Reset mid-MD_WAIT: rst=1 for 1 cycle → clear_l1..l4=1, blocks 0. Afterwards state RUN, counters 0, no residual stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status into the controller, register controls and
// status flags back out to the datapath.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic        id_rs1_used;
  logic [4:0]  id_rs2;
  logic        id_rs2_used;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        ex_redirect;
  logic        ex_md_start;
  logic        md_done;
  logic        mem_req;
  logic        mem_ready;

  logic        block_pc;
  logic        block_l1;
  logic        block_l2;
  logic        block_l3;
  logic        block_l4;
  logic        clear_l1;
  logic        clear_l2;
  logic        clear_l3;
  logic        clear_l4;
  logic        mem_err;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output id_rs1, id_rs1_used, id_rs2, id_rs2_used, ex_rd, ex_is_load, ex_redirect,
           ex_md_start, md_done, mem_req, mem_ready,
    input  block_pc, block_l1, block_l2, block_l3, block_l4,
           clear_l1, clear_l2, clear_l3, clear_l4, mem_err, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs1_used, id_rs2, id_rs2_used, ex_rd, ex_is_load, ex_redirect,
           ex_md_start, md_done, mem_req, mem_ready,
    output block_pc, block_l1, block_l2, block_l3, block_l4,
           clear_l1, clear_l2, clear_l3, clear_l4, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: mem wait > mul/div > redirect > load-use.
// Optional perf counters (stall_cycles, flush_count) are built only with HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   hz
);

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StMdWait = 1'b1;
  localparam logic [TO_W-1:0] WaitMax = {TO_W{1'b1}};

  logic [0:0]      state_q, state_d;
  logic            md_done_pend_q, md_done_pend_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;

  logic mem_stall;
  logic md_stall;
  logic load_use;
  logic redirect_taken;

  always_comb begin
    mem_stall = hz.mem_req & ~hz.mem_ready;
    md_stall  = (hz.ex_md_start | (state_q == StMdWait)) & ~(hz.md_done | md_done_pend_q);
    load_use  = hz.ex_is_load & (hz.ex_rd != 5'd0) &
                ((hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd)) |
                 (hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd)));
  end

  always_comb begin
    hz.block_pc    = 1'b0;
    hz.block_l1    = 1'b0;
    hz.block_l2    = 1'b0;
    hz.block_l3    = 1'b0;
    hz.block_l4    = 1'b0;
    hz.clear_l1    = 1'b0;
    hz.clear_l2    = 1'b0;
    hz.clear_l3    = 1'b0;
    hz.clear_l4    = 1'b0;
    redirect_taken = 1'b0;
    if (rst) begin
      hz.clear_l1 = 1'b1;
      hz.clear_l2 = 1'b1;
      hz.clear_l3 = 1'b1;
      hz.clear_l4 = 1'b1;
    end else if (mem_stall) begin
      hz.block_pc = 1'b1;
      hz.block_l1 = 1'b1;
      hz.block_l2 = 1'b1;
      hz.block_l3 = 1'b1;
      hz.clear_l4 = 1'b1;
    end else if (md_stall) begin
      hz.block_pc = 1'b1;
      hz.block_l1 = 1'b1;
      hz.block_l2 = 1'b1;
      hz.clear_l3 = 1'b1;
    end else if (hz.ex_redirect) begin
      // EX stays frozen during earlier stalls, so a deferred redirect lands here
      hz.clear_l1    = 1'b1;
      hz.clear_l2    = 1'b1;
      redirect_taken = 1'b1;
    end else if (load_use) begin
      hz.block_pc = 1'b1;
      hz.block_l1 = 1'b1;
      hz.clear_l2 = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:    if (hz.ex_md_start && !hz.md_done) state_d = StMdWait;
      StMdWait: if ((hz.md_done || md_done_pend_q) && !mem_stall) state_d = StRun;
      default:  state_d = StRun;
    endcase

    // A done seen under a mem stall is held until the stall lifts; the FSM then leaves
    // MD_WAIT in that same cycle, so the flag never outlives the stall.
    md_done_pend_d = mem_stall & (md_done_pend_q | hz.md_done);

    if (!mem_stall)             wait_cnt_d = '0;
    else if (wait_cnt_q == WaitMax) wait_cnt_d = wait_cnt_q;
    else                        wait_cnt_d = wait_cnt_q + 1'b1;

    mem_err_d = mem_err_q | (mem_stall & (wait_cnt_d >= TO_W'(MEM_TIMEOUT)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      md_done_pend_q <= 1'b0;
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      md_done_pend_q <= md_done_pend_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
    end
  end

  assign hz.mem_err = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, hz.block_pc};
    flush_count_d  = flush_count_q + {31'd0, redirect_taken};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect_taken;
  assign hz.stall_cycles = 32'd0;
  assign hz.flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl with a scoreboard queue of expected outputs.
module tb_pipe_hazard_ctrl;

  typedef struct {
    bit       rst;
    bit [4:0] rs1;
    bit       u1;
    bit [4:0] rs2;
    bit       u2;
    bit [4:0] rd;
    bit       ld;
    bit       rdr;
    bit       mds;
    bit       mdd;
    bit       mrq;
    bit       mrd;
    bit [8:0] o;   // {block_pc, block_l1..l4, clear_l1..l4}
    bit       err;
  } vec_t;

  localparam bit [8:0] ORst = 9'b00000_1111;
  localparam bit [8:0] OLu  = 9'b11000_0100;
  localparam bit [8:0] ORd  = 9'b00000_1100;
  localparam bit [8:0] OMd  = 9'b11100_0010;
  localparam bit [8:0] OMem = 9'b11110_0001;
  localparam bit [8:0] ONon = 9'b00000_0000;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk;
  logic rst;
  pipe_hazard_ctrl_if hz_if ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .TO_W       (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t exp_q[$];
  int unsigned stall_exp = 0;
  int unsigned flush_exp = 0;

  function automatic vec_t mk(bit r, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                              bit [4:0] rd, bit ld, bit rdr, bit mds, bit mdd,
                              bit mrq, bit mrd, bit [8:0] o, bit err);
    vec_t v;
    v.rst = r;   v.rs1 = rs1; v.u1 = u1;   v.rs2 = rs2; v.u2 = u2;
    v.rd = rd;   v.ld = ld;   v.rdr = rdr; v.mds = mds; v.mdd = mdd;
    v.mrq = mrq; v.mrd = mrd; v.o = o;     v.err = err;
    return v;
  endfunction

  function automatic vec_t idle(bit [8:0] o, bit err);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o, err);
  endfunction

  task automatic step(input vec_t v, input string name);
    vec_t e;
    logic [8:0] act;
    @(posedge clk);
    #1;
    rst               = v.rst;
    hz_if.id_rs1      = v.rs1;
    hz_if.id_rs1_used = v.u1;
    hz_if.id_rs2      = v.rs2;
    hz_if.id_rs2_used = v.u2;
    hz_if.ex_rd       = v.rd;
    hz_if.ex_is_load  = v.ld;
    hz_if.ex_redirect = v.rdr;
    hz_if.ex_md_start = v.mds;
    hz_if.md_done     = v.mdd;
    hz_if.mem_req     = v.mrq;
    hz_if.mem_ready   = v.mrd;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    act = {hz_if.block_pc, hz_if.block_l1, hz_if.block_l2, hz_if.block_l3, hz_if.block_l4,
           hz_if.clear_l1, hz_if.clear_l2, hz_if.clear_l3, hz_if.clear_l4};
    n_cmp++;
    if (act !== e.o) begin
      n_bad++;
      $display("FAIL %s ctrl: got %b want %b", name, act, e.o);
    end
    n_cmp++;
    if (hz_if.mem_err !== e.err) begin
      n_bad++;
      $display("FAIL %s mem_err: got %b want %b", name, hz_if.mem_err, e.err);
    end
    n_cmp++;
    if (hz_if.stall_cycles !== stall_exp) begin
      n_bad++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, hz_if.stall_cycles, stall_exp);
    end
    n_cmp++;
    if (hz_if.flush_count !== flush_exp) begin
      n_bad++;
      $display("FAIL %s flush_count: got %0d want %0d", name, hz_if.flush_count, flush_exp);
    end
    if (e.rst) begin
      stall_exp = 0;
      flush_exp = 0;
    end else if (PerfEn) begin
      if (e.o[8]) stall_exp++;
      if (e.o[3]) flush_exp++;
    end
  endtask

  vec_t tab[$];

  initial begin
    rst = 1'b1;
    hz_if.id_rs1 = '0; hz_if.id_rs1_used = 1'b0; hz_if.id_rs2 = '0; hz_if.id_rs2_used = 1'b0;
    hz_if.ex_rd = '0;  hz_if.ex_is_load = 1'b0;  hz_if.ex_redirect = 1'b0;
    hz_if.ex_md_start = 1'b0; hz_if.md_done = 1'b0; hz_if.mem_req = 1'b0;
    hz_if.mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    //        rst rs1 u1 rs2 u2 rd ld rdr mds mdd mrq mrd  out   err
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ORst, 0)); // reset
    tab.push_back(mk(0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, OLu,  0)); // load-use rs1
    tab.push_back(idle(ONon, 0));                                   // load moved on
    tab.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, ONon, 0)); // rd=0 never stalls
    tab.push_back(mk(0, 7, 0, 7, 1, 7, 1, 0, 0, 0, 0, 0, OLu,  0)); // load-use rs2
    tab.push_back(mk(0, 7, 0, 3, 1, 7, 1, 0, 0, 0, 0, 0, ONon, 0)); // unused rs1 match
    tab.push_back(mk(0, 5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, ORd,  0)); // redirect beats load-use
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, OMd,  0)); // md start
    tab.push_back(idle(OMd, 0));
    tab.push_back(idle(OMd, 0));
    tab.push_back(idle(OMd, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ONon, 0)); // md done releases
    tab.push_back(idle(ONon, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, OMd,  0)); // md start again
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OMem, 0)); // mem over md
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, OMem, 0)); // done while mem stall
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OMem, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ONon, 0)); // pending done used
    tab.push_back(idle(ONon, 0));                                   // back in RUN
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, ONon, 0)); // start+done together
    tab.push_back(idle(ONon, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, OMem, 0)); // redirect deferred
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, ORd,  0)); // redirect acted on
    for (int i = 0; i < tab.size(); i++) step(tab[i], $sformatf("vec%0d", i));

    // MEM timeout: error after the 4th consecutive stall cycle, sticky until reset
    for (int i = 0; i < 4; i++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OMem, 0), $sformatf("to_wait%0d", i));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OMem, 1), "to_err");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ONon, 1), "to_ready");
    step(idle(ONon, 1), "to_sticky");

    // Reset in the middle of an MD stall
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, OMd, 1), "rst_md_start");
    step(idle(OMd, 1), "rst_md_wait");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ORst, 1), "rst_pulse");
    step(idle(ONon, 0), "rst_after");
    step(idle(ONon, 0), "rst_after2");

    // Redirect deferred behind an MD stall
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, OMd, 0), "md_rdr_hold");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, ORd, 0), "md_rdr_go");
    step(idle(ONon, 0), "md_rdr_done");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
